// File: rtl/dec_scan_pkg.sv
// Shared types and helpers for the dec_scan_n address decoder / display scanner.
// onehot() is sized for the widest supported address; callers cast the result to their width.
package dec_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DECODE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Largest address width any instance may use (ADDR_W <= MAX_ADDR_W)
    localparam int MAX_ADDR_W = 8;
    localparam int MAX_OUT_W  = 2 ** MAX_ADDR_W;

    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_ADDR_W-1:0] addr);
        logic [MAX_OUT_W-1:0] vec;
        vec       = '0;
        vec[addr] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/tick_div.sv
// Prescaler: counts 0..DIV-1 and flags the last count; a synchronous clear restarts the phase.
// Suitable for any display-refresh timebase, not only the scanner.
module tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || count == LAST_CNT) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == LAST_CNT);

endmodule

// File: rtl/dec_scan_n.sv
// Registered address decoder with a prescaled scan mode that walks the active line 0..LAST.
// All outputs are registered; dout is always the decode of the value idx takes on the same edge.
module dec_scan_n
    import dec_scan_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int LAST       = 2 ** ADDR_W - 1,
    parameter int DIV        = 4,
    parameter bit ACTIVE_LOW = 1'b0,
    localparam int OUT_W     = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic              load,
    output logic [OUT_W-1:0]  dout,
    output logic [ADDR_W-1:0] idx,
    output logic              valid,
    output logic              wrap
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LAST);
    localparam logic [OUT_W-1:0]  INACTIVE = {OUT_W{ACTIVE_LOW}};

    state_t            state, next_state;
    logic              scan_restart;
    logic              pre_clear;
    logic              tick;
    logic [ADDR_W-1:0] start_idx;
    logic [ADDR_W-1:0] idx_next;
    logic              valid_next;
    logic              wrap_next;
    logic [OUT_W-1:0]  decoded;

    // Entering scan or a load restarts the walk from addr; any other state keeps the prescaler at 0
    assign scan_restart = (next_state == SCAN) && ((state != SCAN) || load);
    assign pre_clear    = (next_state != SCAN) || scan_restart;
    assign start_idx    = (addr > LAST_IDX) ? '0 : addr;

    tick_div #(.DIV(DIV)) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (pre_clear),
        .tick  (tick)
    );

    always_comb begin
        next_state = IDLE;
        if (en) begin
            next_state = (mode == MODE_SCAN) ? SCAN : DECODE;
        end
    end

    always_comb begin
        idx_next   = idx;
        valid_next = 1'b0;
        wrap_next  = 1'b0;
        case (next_state)
            DECODE: begin
                idx_next   = addr;
                valid_next = 1'b1;
            end
            SCAN: begin
                valid_next = 1'b1;
                if (scan_restart) begin
                    idx_next = start_idx;
                end else if (tick) begin
                    if (idx == LAST_IDX) begin
                        idx_next  = '0;
                        wrap_next = 1'b1;
                    end else begin
                        idx_next = idx + ADDR_W'(1);
                    end
                end
            end
            default: idx_next = idx;
        endcase
        decoded = valid_next ? OUT_W'(onehot(MAX_ADDR_W'(idx_next))) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
            dout  <= INACTIVE;
        end else begin
            state <= next_state;
            idx   <= idx_next;
            valid <= valid_next;
            wrap  <= wrap_next;
            dout  <= ACTIVE_LOW ? ~decoded : decoded;
        end
    end

endmodule

// File: tb/tb_dec_scan_n.sv
// Bench for dec_scan_n: four instances with different LAST/DIV/ACTIVE_LOW share one stimulus stream.
// Directed tables and sequences plus a randomized run against a per-instance reference model.
module tb_dec_scan_n;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             mode;
    logic             load;
    logic [3:0]       addr;
    logic [3:0][15:0] dout_a;
    logic [3:0][3:0]  idx_a;
    logic [3:0]       valid_a;
    logic [3:0]       wrap_a;

    int total = 0;
    int bad   = 0;

    int p_last [4] = '{15, 5, 15, 0};
    int p_div  [4] = '{4, 3, 1, 2};
    bit p_al   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    int m_idx  [4];
    bit m_valid[4];
    bit m_wrap [4];
    bit m_scan [4];
    int m_held [4];

    always #5 clk = ~clk;

    dec_scan_n #(.ADDR_W(4), .LAST(15), .DIV(4), .ACTIVE_LOW(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .addr(addr), .load(load),
        .dout(dout_a[0]), .idx(idx_a[0]), .valid(valid_a[0]), .wrap(wrap_a[0]));
    dec_scan_n #(.ADDR_W(4), .LAST(5), .DIV(3), .ACTIVE_LOW(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .addr(addr), .load(load),
        .dout(dout_a[1]), .idx(idx_a[1]), .valid(valid_a[1]), .wrap(wrap_a[1]));
    dec_scan_n #(.ADDR_W(4), .LAST(15), .DIV(1), .ACTIVE_LOW(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .addr(addr), .load(load),
        .dout(dout_a[2]), .idx(idx_a[2]), .valid(valid_a[2]), .wrap(wrap_a[2]));
    dec_scan_n #(.ADDR_W(4), .LAST(0), .DIV(2), .ACTIVE_LOW(1'b0)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .addr(addr), .load(load),
        .dout(dout_a[3]), .idx(idx_a[3]), .valid(valid_a[3]), .wrap(wrap_a[3]));

    typedef struct {
        logic        en;
        logic        mode;
        logic [3:0]  addr;
        logic [15:0] exp_hi;
        logic [15:0] exp_lo;
        logic        exp_valid;
    } vec_t;

    task automatic check_val(input string name, input int k, input logic [15:0] act,
                             input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s u%0d: got %h, expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_idx[k]   = 0;
            m_valid[k] = 1'b0;
            m_wrap[k]  = 1'b0;
            m_scan[k]  = 1'b0;
            m_held[k]  = 0;
        end
    endtask

    // Reference: an index is shown for DIV cycles, then moves on; entering scan or load restarts it
    task automatic model_step();
        for (int k = 0; k < 4; k++) begin
            m_wrap[k] = 1'b0;
            if (!en) begin
                m_valid[k] = 1'b0;
                m_scan[k]  = 1'b0;
            end else if (!mode) begin
                m_idx[k]   = int'(addr);
                m_valid[k] = 1'b1;
                m_scan[k]  = 1'b0;
            end else begin
                m_valid[k] = 1'b1;
                if (!m_scan[k] || load) begin
                    m_idx[k]  = (int'(addr) > p_last[k]) ? 0 : int'(addr);
                    m_held[k] = 1;
                    m_scan[k] = 1'b1;
                end else if (m_held[k] == p_div[k]) begin
                    m_wrap[k] = (m_idx[k] == p_last[k]);
                    m_idx[k]  = (m_idx[k] + 1) % (p_last[k] + 1);
                    m_held[k] = 1;
                end else begin
                    m_held[k]++;
                end
            end
        end
    endtask

    task automatic check_output();
        logic [15:0] e;
        for (int k = 0; k < 4; k++) begin
            e = m_valid[k] ? (16'd1 << m_idx[k]) : 16'd0;
            if (p_al[k]) e = ~e;
            check_val("model_dout", k, dout_a[k], e);
            check_val("model_idx", k, 16'(idx_a[k]), 16'(m_idx[k]));
            check_val("model_valid", k, 16'(valid_a[k]), 16'(m_valid[k]));
            check_val("model_wrap", k, 16'(wrap_a[k]), 16'(m_wrap[k]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_output();
    endtask

    task automatic apply_stimulus(input logic e, input logic m, input logic [3:0] a, input logic l);
        en   = e;
        mode = m;
        addr = a;
        load = l;
        cycle();
    endtask

    initial begin
        vec_t vecs[6];
        int   seq_idx[10];
        bit   seq_wrap[10];

        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 1'b0;
        load  = 1'b0;
        addr  = '0;
        model_reset();
        #12;
        check_output();
        rst_n = 1'b1;

        // Decode sweep on the active-high and active-low instances, ending with en low
        vecs[0] = '{1'b1, 1'b0, 4'd0,  16'h0001, 16'hFFFE, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 4'd7,  16'h0080, 16'hFF7F, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 4'd10, 16'h0400, 16'hFBFF, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 4'd15, 16'h8000, 16'h7FFF, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 4'd3,  16'h0008, 16'hFFF7, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 4'd3,  16'h0000, 16'hFFFF, 1'b0};
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].en, vecs[i].mode, vecs[i].addr, 1'b0);
            check_val("tbl_dout", 0, dout_a[0], vecs[i].exp_hi);
            check_val("tbl_dout_al", 2, dout_a[2], vecs[i].exp_lo);
            check_val("tbl_valid", 0, 16'(valid_a[0]), 16'(vecs[i].exp_valid));
            check_val("tbl_valid_al", 2, 16'(valid_a[2]), 16'(vecs[i].exp_valid));
        end

        // Scan from 4 with DIV=3, LAST=5
        seq_idx  = '{4, 4, 4, 5, 5, 5, 0, 0, 0, 1};
        seq_wrap = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 1'b1, 4'd4, 1'b0);
            check_val("scan_idx", 1, 16'(idx_a[1]), 16'(seq_idx[i]));
            check_val("scan_wrap", 1, 16'(wrap_a[1]), 16'(seq_wrap[i]));
        end

        // Start index beyond LAST clamps to 0
        apply_stimulus(1'b0, 1'b1, 4'd9, 1'b0);
        apply_stimulus(1'b1, 1'b1, 4'd9, 1'b0);
        check_val("clamp_idx", 1, 16'(idx_a[1]), 16'd0);
        check_val("noclamp_idx", 0, 16'(idx_a[0]), 16'd9);

        // Load collides with the step tick at idx == LAST
        apply_stimulus(1'b0, 1'b1, 4'd5, 1'b0);
        apply_stimulus(1'b1, 1'b1, 4'd5, 1'b0);
        check_val("coll_entry", 1, 16'(idx_a[1]), 16'd5);
        apply_stimulus(1'b1, 1'b1, 4'd5, 1'b0);
        apply_stimulus(1'b1, 1'b1, 4'd5, 1'b0);
        apply_stimulus(1'b1, 1'b1, 4'd2, 1'b1);
        check_val("coll_idx", 1, 16'(idx_a[1]), 16'd2);
        check_val("coll_wrap", 1, 16'(wrap_a[1]), 16'd0);
        apply_stimulus(1'b1, 1'b1, 4'd2, 1'b0);
        apply_stimulus(1'b1, 1'b1, 4'd2, 1'b0);
        check_val("coll_hold", 1, 16'(idx_a[1]), 16'd2);
        apply_stimulus(1'b1, 1'b1, 4'd2, 1'b0);
        check_val("coll_step", 1, 16'(idx_a[1]), 16'd3);

        // Scan -> decode -> scan with addr 12
        apply_stimulus(1'b1, 1'b0, 4'd12, 1'b0);
        check_val("sw_dout", 0, dout_a[0], 16'h1000);
        apply_stimulus(1'b1, 1'b1, 4'd12, 1'b0);
        check_val("sw_idx", 0, 16'(idx_a[0]), 16'd12);
        check_val("sw_clamp", 1, 16'(idx_a[1]), 16'd0);
        apply_stimulus(1'b1, 1'b1, 4'd12, 1'b0);

        // Asynchronous reset mid-scan, between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check_val("rst_dout", k, dout_a[k], p_al[k] ? 16'hFFFF : 16'h0000);
            check_val("rst_idx", k, 16'(idx_a[k]), 16'd0);
            check_val("rst_valid", k, 16'(valid_a[k]), 16'd0);
            check_val("rst_wrap", k, 16'(wrap_a[k]), 16'd0);
        end
        model_reset();
        rst_n = 1'b1;

        // Randomized run against the reference model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            en   = ($urandom_range(0, 15) != 0);
            addr = 4'($urandom_range(0, 15));
            load = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_output();
                rst_n = 1'b1;
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
